// File: rtl/program_loader_if.sv
// Loader-side bundle: the incoming byte stream plus the instruction-memory write port.
// The loader takes the master view; the host/memory side takes the slave view.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: length-prefixed byte stream in, little-endian
// 32-bit words out to the imem write port; the core stays in reset until the load ends.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  localparam logic [ADDR_WIDTH:0] WORD_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [31:0]         CAPACITY = 32'd1 << ADDR_WIDTH;

  state_t              state;
  state_t              state_next;

  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [1:0]          byte_idx;
  logic [ADDR_WIDTH:0] word_idx;
  logic [23:0]         asm_word;

  logic                accept;
  logic [15:0]         len_word;
  logic                too_long;
  logic                last_word;

  assign accept   = bus.in_valid & bus.in_ready;
  assign len_word = {bus.in_data, len_lo};
  assign too_long = {16'd0, len_word} > CAPACITY;

  // Word index is one bit wider than the address so a full-capacity load can count to N.
  assign last_word = ({{(31 - ADDR_WIDTH){1'b0}}, word_idx} + 32'd1) == {16'd0, len};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if (len_word == 16'd0) state_next = DONE;
          else if (too_long)     state_next = ERROR;
          else                   state_next = DATA;
        end
      end
      DATA: begin
        if (accept && (byte_idx == 2'd3) && last_word) state_next = FLUSH;
      end
      FLUSH:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  // Status outputs are registered from the next state, so they track the state exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_next;
      bus.in_ready <= state_next inside {LEN_LO, LEN_HI, DATA};
      cpu_reset    <= state_next != DONE;
      busy         <= state_next inside {LEN_LO, LEN_HI, DATA, FLUSH};
      done         <= state_next == DONE;
      error        <= state_next == ERROR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len_lo         <= 8'd0;
      len            <= 16'd0;
      byte_idx       <= 2'd0;
      word_idx       <= '0;
      asm_word       <= 24'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
    end else begin
      bus.imem_we <= 1'b0;
      if (accept) begin
        case (state)
          LEN_LO: len_lo <= bus.in_data;
          LEN_HI: begin
            len      <= len_word;
            byte_idx <= 2'd0;
            word_idx <= '0;
          end
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            // Lanes 0..2 are held; the word is only ever written whole, on lane 3.
            case (byte_idx)
              2'd0: asm_word[7:0]   <= bus.in_data;
              2'd1: asm_word[15:8]  <= bus.in_data;
              2'd2: asm_word[23:16] <= bus.in_data;
              default: begin
                bus.imem_wdata <= {bus.in_data, asm_word};
                bus.imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                bus.imem_we    <= 1'b1;
                word_idx       <= word_idx + WORD_ONE;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (ADDR_WIDTH 8 and 4) driven with
// directed and random length-prefixed streams, checked against a stream-decoding model.
module tb_program_loader;

  typedef logic [7:0] byte_q_t[$];

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0] start;
  logic [1:0] vld;
  logic [7:0] dat [2];

  program_loader_if #(.ADDR_WIDTH(8)) bus8 ();
  program_loader_if #(.ADDR_WIDTH(4)) bus4 ();

  logic [1:0]  cpu_rst;
  logic [1:0]  busy_s;
  logic [1:0]  done_s;
  logic [1:0]  err_s;
  logic [1:0]  rdy;
  logic [1:0]  we;
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s [2];

  assign bus8.in_valid = vld[0];
  assign bus8.in_data  = dat[0];
  assign bus4.in_valid = vld[1];
  assign bus4.in_data  = dat[1];
  assign rdy           = {bus4.in_ready, bus8.in_ready};
  assign we            = {bus4.imem_we, bus8.imem_we};
  assign addr_s[0]     = 32'(bus8.imem_addr);
  assign addr_s[1]     = 32'(bus4.imem_addr);
  assign wdata_s[0]    = bus8.imem_wdata;
  assign wdata_s[1]    = bus4.imem_wdata;

  program_loader #(.ADDR_WIDTH(8)) dut8 (
    .clock     (clock),
    .reset     (reset),
    .start     (start[0]),
    .bus       (bus8.master),
    .cpu_reset (cpu_rst[0]),
    .busy      (busy_s[0]),
    .done      (done_s[0]),
    .error     (err_s[0])
  );

  program_loader #(.ADDR_WIDTH(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .start     (start[1]),
    .bus       (bus4.master),
    .cpu_reset (cpu_rst[1]),
    .busy      (busy_s[1]),
    .done      (done_s[1]),
    .error     (err_s[1])
  );

  int tests_run = 0;
  int fails     = 0;

  // Write monitor: logs every imem write and flags protocol oddities per instance.
  int          cyc = 0;
  logic [31:0] w_addr [2][2048];
  logic [31:0] w_data [2][2048];
  int          w_cnt [2]       = '{0, 0};
  int          last_we_cyc [2] = '{-100, -100};
  int          close_we [2]    = '{0, 0};
  int          rdy_drop [2]    = '{0, 0};

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (we[s] === 1'b1) begin
        w_addr[s][w_cnt[s] % 2048] <= addr_s[s];
        w_data[s][w_cnt[s] % 2048] <= wdata_s[s];
        w_cnt[s]                   <= w_cnt[s] + 1;
        last_we_cyc[s]             <= cyc;
        if (cyc - last_we_cyc[s] < 4) close_we[s] <= close_we[s] + 1;
      end
      if (busy_s[s] === 1'b1 && rdy[s] !== 1'b1 && we[s] !== 1'b1) rdy_drop[s] <= rdy_drop[s] + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic byte_q_t make_stream(input int n, input logic [31:0] words[$]);
    byte_q_t q;
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    foreach (words[i]) begin
      q.push_back(words[i][7:0]);
      q.push_back(words[i][15:8]);
      q.push_back(words[i][23:16]);
      q.push_back(words[i][31:24]);
    end
    return q;
  endfunction

  task automatic do_start(input int s, input string name);
    @(negedge clock); start[s] = 1'b1;
    @(negedge clock); start[s] = 1'b0;
    tests_run++;
    if (rdy[s] !== 1'b1 || cpu_rst[s] !== 1'b1 || done_s[s] !== 1'b0 || err_s[s] !== 1'b0) begin
      fails++;
      $display("FAIL %s start: in_ready=%b cpu_reset=%b done=%b error=%b, want 1 1 0 0",
               name, rdy[s], cpu_rst[s], done_s[s], err_s[s]);
    end
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input int gap, input string name);
    int t;
    repeat (gap) begin @(negedge clock); vld[s] = 1'b0; end
    @(negedge clock); vld[s] = 1'b1; dat[s] = b;
    t = 0;
    while (rdy[s] !== 1'b1 && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) begin
      tests_run++;
      fails++;
      $display("FAIL %s send_timeout: in_ready stayed %b for 50 cycles, want 1", name, rdy[s]);
    end
  endtask

  // Full load with reference decoding of the stream: N from the header, then N words LSB first.
  task automatic run_load(input int s, input int aw, input byte_q_t bytes, input int gap_mode,
                          input bit poke, input string name);
    logic [31:0] exp_w[$];
    bit          exp_done;
    bit          exp_err;
    int          n, base, drop0, close0, lat, exp_lat, got_n;

    n        = int'(bytes[0]) | (int'(bytes[1]) << 8);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0) exp_done = 1'b1;
    else if (n > (1 << aw)) exp_err = 1'b1;
    else begin
      exp_done = 1'b1;
      for (int i = 0; i < n; i++)
        exp_w.push_back({bytes[2+4*i+3], bytes[2+4*i+2], bytes[2+4*i+1], bytes[2+4*i]});
    end
    exp_lat = (exp_w.size() > 0) ? 1 : 0;

    base   = w_cnt[s];
    drop0  = rdy_drop[s];
    close0 = close_we[s];
    do_start(s, name);
    foreach (bytes[i]) begin
      int g;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (poke && i == 6) start[s] = 1'b1;
      send_byte(s, bytes[i], g, name);
      start[s] = 1'b0;
    end
    @(negedge clock); vld[s] = 1'b0;
    lat = 0;
    while (done_s[s] !== 1'b1 && err_s[s] !== 1'b1 && lat < 50) begin
      @(negedge clock); lat++;
    end
    @(negedge clock);

    tests_run++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s latency: finished %0d cycles after last byte, want %0d", name, lat, exp_lat);
    end
    got_n = w_cnt[s] - base;
    tests_run++;
    if (got_n !== exp_w.size()) begin
      fails++;
      $display("FAIL %s write_count: got %0d writes, want %0d", name, got_n, exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_n; i++) begin
      tests_run++;
      if (w_addr[s][(base + i) % 2048] !== 32'(i) || w_data[s][(base + i) % 2048] !== exp_w[i]) begin
        fails++;
        $display("FAIL %s write[%0d]: got addr %0h data %h, want addr %0h data %h", name, i,
                 w_addr[s][(base + i) % 2048], w_data[s][(base + i) % 2048], i, exp_w[i]);
      end
    end
    tests_run++;
    if (done_s[s] !== exp_done || err_s[s] !== exp_err || cpu_rst[s] !== !exp_done || rdy[s] !== 1'b0) begin
      fails++;
      $display("FAIL %s final: done=%b error=%b cpu_reset=%b in_ready=%b, want %b %b %b 0", name,
               done_s[s], err_s[s], cpu_rst[s], rdy[s], exp_done, exp_err, !exp_done);
    end
    tests_run++;
    if (rdy_drop[s] - drop0 !== 0 || close_we[s] - close0 !== 0) begin
      fails++;
      $display("FAIL %s protocol: in_ready drops=%0d close imem_we pulses=%0d, want 0 0", name,
               rdy_drop[s] - drop0, close_we[s] - close0);
    end
  endtask

  task automatic test_reset();
    start = 2'b11; vld = 2'b11; dat[0] = 8'hAA; dat[1] = 8'h55;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clock);
      if (pass == 1) begin end
      for (int s = 0; s < 2; s++) begin
        tests_run++;
        if (cpu_rst[s] !== 1'b1 || rdy[s] !== 1'b0 || busy_s[s] !== 1'b0 || done_s[s] !== 1'b0 ||
            err_s[s] !== 1'b0 || we[s] !== 1'b0 || addr_s[s] !== 32'd0 || wdata_s[s] !== 32'd0) begin
          fails++;
          $display("FAIL reset[%0d] pass%0d: cpu_reset=%b in_ready=%b busy=%b done=%b error=%b we=%b addr=%0h wdata=%h, want 1 0 0 0 0 0 0 0",
                   s, pass, cpu_rst[s], rdy[s], busy_s[s], done_s[s], err_s[s], we[s], addr_s[s], wdata_s[s]);
        end
      end
      reset = 1'b0; start = 2'b00; vld = 2'b00;
      repeat (2) @(negedge clock);
    end
    for (int s = 0; s < 2; s++) begin
      tests_run++;
      if (w_cnt[s] !== 0) begin
        fails++;
        $display("FAIL reset_no_write[%0d]: got %0d writes, want 0", s, w_cnt[s]);
      end
    end
  endtask

  task automatic test_two_word();
    logic [31:0] w[$];
    w.push_back(32'h12345678);
    w.push_back(32'hDEADBEEF);
    run_load(0, 8, make_stream(2, w), 0, 1'b0, "two_word");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    run_load(0, 8, make_stream(3, w), 0, 1'b0, "b2b_first");
    w.delete();
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    run_load(0, 8, make_stream(4, w), 0, 1'b0, "b2b_second");
  endtask

  task automatic test_backpressure();
    logic [31:0] w[$];
    w.push_back(32'h12345678);
    w.push_back(32'hDEADBEEF);
    run_load(0, 8, make_stream(2, w), 1, 1'b0, "alternating");
    run_load(0, 8, make_stream(2, w), 2, 1'b0, "random_gaps");
  endtask

  task automatic test_zero_length();
    logic [31:0] none[$];
    run_load(0, 8, make_stream(0, none), 0, 1'b0, "zero_len");
    run_load(1, 4, make_stream(0, none), 2, 1'b0, "zero_len_aw4");
  endtask

  task automatic test_capacity();
    logic [31:0] none[$];
    logic [31:0] w[$];
    run_load(1, 4, make_stream(17, none), 0, 1'b0, "over_cap_aw4");
    for (int i = 0; i < 16; i++) w.push_back($urandom);
    run_load(1, 4, make_stream(16, w), 0, 1'b0, "full_cap_aw4");
    run_load(0, 8, make_stream(257, none), 0, 1'b0, "over_cap_aw8");
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    run_load(0, 8, make_stream(256, w), 0, 1'b0, "full_cap_aw8");
  endtask

  task automatic test_reset_midload();
    logic [31:0] w[$];
    byte_q_t     q;
    int          base;
    w.push_back($urandom);
    w.push_back($urandom);
    q    = make_stream(2, w);
    base = w_cnt[0];
    do_start(0, "midload");
    for (int i = 0; i < 8; i++) send_byte(0, q[i], 0, "midload");
    @(negedge clock); vld[0] = 1'b0; reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    repeat (6) @(negedge clock);
    tests_run++;
    if (w_cnt[0] - base !== 1) begin
      fails++;
      $display("FAIL midload write_count: got %0d writes, want 1", w_cnt[0] - base);
    end else begin
      tests_run++;
      if (w_addr[0][base % 2048] !== 32'd0 || w_data[0][base % 2048] !== w[0]) begin
        fails++;
        $display("FAIL midload write0: got addr %0h data %h, want addr 0 data %h",
                 w_addr[0][base % 2048], w_data[0][base % 2048], w[0]);
      end
    end
    tests_run++;
    if (cpu_rst[0] !== 1'b1 || busy_s[0] !== 1'b0 || rdy[0] !== 1'b0 || done_s[0] !== 1'b0) begin
      fails++;
      $display("FAIL midload idle: cpu_reset=%b busy=%b in_ready=%b done=%b, want 1 0 0 0",
               cpu_rst[0], busy_s[0], rdy[0], done_s[0]);
    end
    run_load(0, 8, q, 0, 1'b0, "reload");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] w[$];
      int          s, aw, n;
      s  = k % 2;
      aw = (s == 0) ? 8 : 4;
      n  = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_load(s, aw, make_stream(n, w), int'($urandom_range(0, 2)), k[0] == 1'b0, "random");
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 2'b00;
    vld    = 2'b00;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    test_reset();
    test_two_word();
    test_back_to_back();
    test_backpressure();
    test_zero_length();
    test_capacity();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction-memory writer for the single-cycle RISC-V core. It accepts a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. It writes them sequentially into the instruction memory's write port, which the IFU reads from. It holds the processor in reset (`cpu_reset`) until the full program has been written.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a load; honoured only in IDLE, DONE or ERROR.
- `in_valid`  in  1: `in_data` holds a byte.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte. A byte transfers on a clock edge where `in_valid & in_ready`.
- `imem_we`  out  1: one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_WIDTH: word address for the write.
- `imem_wdata`  out  32: instruction word for the write.
- `cpu_reset`  out  1: drives the processor's `reset`; high while no valid program is loaded.
- `busy`  out  1: high in LEN_LO, LEN_HI, DATA and FLUSH.
- `done`  out  1: program loaded; core released.
- `error`  out  1: rejected length; core held.

## Operation
- Stream format:
  - byte 0 = word count N[7:0];
  - byte 1 = N[15:8];
  - then 4N bytes, least-significant byte of each word first.
  - Words go to addresses 0..N-1 in order.
- States: IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERROR.
- Transitions:
  - IDLE/DONE/ERROR + `start` -> LEN_LO.
  - LEN_LO + byte accepted -> LEN_HI; store N[7:0].
  - LEN_HI + byte accepted:
    - N==0 -> DONE;
    - N > 2^ADDR_WIDTH -> ERROR;
    - otherwise -> DATA. Clear byte index and word index.
  - DATA + byte accepted: shift the byte into the assembly register at lane byte_idx; byte_idx wraps 3->0.
    - On lane 3: register `imem_wdata` = assembled word and `imem_addr` = word_idx, and pulse `imem_we`.
    - word_idx increments. If this was word N-1 -> FLUSH, else stay in DATA.
  - FLUSH -> DONE unconditionally. This is the cycle in which the final `imem_we` is high.
- `start` is ignored in LEN_LO, LEN_HI, DATA and FLUSH. `in_valid` is ignored whenever `in_ready`=0.
- Moore outputs, all registered and derived from state:
  - `in_ready` = 1 in LEN_LO/LEN_HI/DATA, else 0.
  - `cpu_reset` = 0 only in DONE.
  - `done` = 1 only in DONE.
  - `error` = 1 only in ERROR.
- Word index is ADDR_WIDTH+1 bits wide internally, so N = 2^ADDR_WIDTH is legal. N is compared as 16 bits.
- A partially assembled word is never written.

## Timing
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0.
- `reset` overrides everything on the same edge, including mid-load. Memory contents already written are left as-is.
- Throughput is one byte per cycle. `imem_we` is high for exactly the one cycle following the edge that accepted lane 3, and is never high for two consecutive words unless four bytes arrived between them.
- Last word: the 4th byte is accepted at edge k. `imem_we`=1 during cycle k->k+1 (FLUSH). At edge k+1, state becomes DONE, `cpu_reset` falls and `done` rises. The core therefore leaves reset only after the final write has committed.
- `start` in DONE at edge j: from edge j, `cpu_reset`=1 and `done`=0 (state LEN_LO); `in_ready`=1.
- Gaps in `in_valid` stall assembly without side effects.

## Test plan
- Reset:
  - Stimulus: assert `reset` 2 cycles with `start`=1 and `in_valid`=1.
  - Required: `cpu_reset`=1, all other outputs 0, state IDLE; no `imem_we`.
- Two-word load:
  - Stimulus: `start`; bytes 02 00 78 56 34 12 EF BE AD DE back-to-back.
  - Required: `imem_we` pulses with addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF. `cpu_reset` falls and `done` rises one cycle after the second pulse.
- Backpressure and gaps:
  - Stimulus: same stream with `in_valid` low on alternating cycles, plus random gaps.
  - Required: identical writes, exactly 2 `imem_we` pulses, `in_ready` high throughout load.
- Zero length:
  - Stimulus: `start`, bytes 00 00.
  - Required: DONE one edge after the 2nd byte; no `imem_we`; `cpu_reset`=0.
- Capacity boundary, ADDR_WIDTH=4:
  - Stimulus: length 0x0011.
  - Required: `error`=1, `cpu_reset`=1, `in_ready`=0, no writes.
  - Stimulus: `start`, then length 0x0010 with 64 bytes.
  - Required: 16 writes at addr 0..15, then `done`=1.
- Reset mid-load and reload:
  - Stimulus: after 6 data bytes of a 2-word load, pulse `reset`.
  - Required: only addr 0 written; the partial second word is never written; returns to IDLE with `cpu_reset`=1.
  - Stimulus: a subsequent `start` plus full stream.
  - Required: completes normally.
